// File: rtl/memory_pkg.sv
// memory_pkg: shared types for the card-selection front end of the memory game.
//   NUM_CARDS   - number of cards on the board (16)
//   card_idx_t  - 4-bit card index
//   sel_state_t - selection FSM state (no pick, one pick, pair held)
// Optional feature macro: SKIP_MATCHED_EN adds skip_matched(), a cursor search
// that jumps over cards that are already paired.
package memory_pkg;

    localparam int NUM_CARDS = 16;

    typedef logic [3:0] card_idx_t;

    typedef enum logic [1:0] {
        S_NONE = 2'd0,
        S_ONE  = 2'd1,
        S_PAIR = 2'd2
    } sel_state_t;

`ifdef SKIP_MATCHED_EN
    // Walk away from cur in the requested direction and return the first
    // unmatched card; if every other card is matched the cursor stays put.
    function automatic card_idx_t skip_matched(card_idx_t cur, logic up,
                                               logic [NUM_CARDS-1:0] m);
        card_idx_t res;
        card_idx_t cand;
        logic      found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < NUM_CARDS; i++) begin
            cand = up ? cur + card_idx_t'(i) : cur - card_idx_t'(i);
            if (!found && !m[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stability counter and press detector
// for one active-low push button.
//   clk   - system clock
//   rst   - asynchronous reset, active-low
//   btn_n - raw button, active-low (0 = pressed)
//   press - one-cycle pulse per accepted press (released -> pressed)
// Parameter DEBOUNCE_CYCLES: consecutive equal synchronized samples needed
// before the debounced level follows the input.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] arm_cnt_q, arm_cnt_d;
    logic          press_q, press_d;

    // The debounced level flips once the synchronized input has disagreed
    // with it for DEBOUNCE_CYCLES samples in a row. Press events are only
    // allowed after a stable release has been seen since reset, so a button
    // held through reset release never produces an event.
    always_comb begin
        sync1_d   = btn_n;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        cnt_d     = '0;
        armed_d   = armed_q;
        arm_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (!armed_q && sync2_q && deb_q) begin
            if (arm_cnt_q == LAST) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + CW'(1);
            end
        end
        press_d = armed_q & deb_q & ~deb_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            arm_cnt_q <= arm_cnt_d;
            press_q   <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/card_selector.sv
// card_selector: moves a cursor over 16 cards with left/right buttons and
// collects up to two card picks with the select button.
//   clk, rst          - system clock, asynchronous active-low reset
//   izq, der, sel     - raw left/right/select buttons, active-low
//   enable            - game FSM currently accepts picks
//   matched[15:0]     - cards already paired
//   clear             - pair consumed, drop held picks
//   cursor            - highlighted card
//   pick_a, pick_b    - first and second picked card
//   sel_count         - number of picks held (0..2)
//   pick_valid        - one-cycle pulse per accepted pick
//   pair_ready        - two picks held
// Optional feature macro: SKIP_MATCHED_EN makes moves skip matched cards.
module card_selector
    import memory_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 izq,
    input  logic                 der,
    input  logic                 sel,
    input  logic                 enable,
    input  logic [NUM_CARDS-1:0] matched,
    input  logic                 clear,
    output logic [3:0]           cursor,
    output logic [3:0]           pick_a,
    output logic [3:0]           pick_b,
    output logic [1:0]           sel_count,
    output logic                 pick_valid,
    output logic                 pair_ready
);

    logic izq_ev, der_ev, sel_ev;
    logic left_ev, right_ev, sel_go;

    sel_state_t state_q, state_d;
    card_idx_t  cursor_q, cursor_d;
    card_idx_t  pick_a_q, pick_a_d;
    card_idx_t  pick_b_q, pick_b_d;
    logic       pick_valid_q, pick_valid_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_izq (
        .clk(clk), .rst(rst), .btn_n(izq), .press(izq_ev));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_der (
        .clk(clk), .rst(rst), .btn_n(der), .press(der_ev));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
        .clk(clk), .rst(rst), .btn_n(sel), .press(sel_ev));

    // Events are dropped entirely while enable is low. The pick always uses
    // cursor_q, i.e. the cursor before any same-cycle move. Opposite moves
    // in the same cycle cancel out. clear wins over a same-cycle select but
    // leaves the cursor and the stored picks alone.
    always_comb begin
        left_ev      = izq_ev & enable;
        right_ev     = der_ev & enable;
        sel_go       = sel_ev & enable & ~matched[cursor_q];
        cursor_d     = cursor_q;
        state_d      = state_q;
        pick_a_d     = pick_a_q;
        pick_b_d     = pick_b_q;
        pick_valid_d = 1'b0;
        if (left_ev ^ right_ev) begin
`ifdef SKIP_MATCHED_EN
            cursor_d = skip_matched(cursor_q, right_ev, matched);
`else
            cursor_d = right_ev ? cursor_q + 4'd1 : cursor_q - 4'd1;
`endif
        end
        if (clear) begin
            state_d = S_NONE;
        end else if (sel_go) begin
            case (state_q)
                S_NONE: begin
                    pick_a_d     = cursor_q;
                    pick_valid_d = 1'b1;
                    state_d      = S_ONE;
                end
                S_ONE: begin
                    if (cursor_q != pick_a_q) begin
                        pick_b_d     = cursor_q;
                        pick_valid_d = 1'b1;
                        state_d      = S_PAIR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_NONE;
            cursor_q     <= '0;
            pick_a_q     <= '0;
            pick_b_q     <= '0;
            pick_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            pick_a_q     <= pick_a_d;
            pick_b_q     <= pick_b_d;
            pick_valid_q <= pick_valid_d;
        end
    end

    always_comb begin
        sel_count = 2'd0;
        case (state_q)
            S_ONE:   sel_count = 2'd1;
            S_PAIR:  sel_count = 2'd2;
            default: sel_count = 2'd0;
        endcase
    end

    assign cursor     = cursor_q;
    assign pick_a     = pick_a_q;
    assign pick_b     = pick_b_q;
    assign pick_valid = pick_valid_q;
    assign pair_ready = (state_q == S_PAIR);

endmodule

// File: tb/tb_card_selector.sv
// tb_card_selector: randomized bench for card_selector with an abstract
// reference model (cursor position, list of held picks) and a scoreboard.
// Every accepted pick pushes the expected pick registers and count into a
// queue; a monitor pops one entry on each pick_valid pulse.
// Honors SKIP_MATCHED_EN in its reference model.
module tb_card_selector;

    localparam int DEB = 4;

    logic        clk;
    logic        rst;
    logic        izq, der, sel, enable, clear;
    logic [15:0] matched;
    logic [3:0]  cursor, pick_a, pick_b;
    logic [1:0]  sel_count;
    logic        pick_valid, pair_ready;

    card_selector #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .izq(izq), .der(der), .sel(sel),
        .enable(enable), .matched(matched), .clear(clear),
        .cursor(cursor), .pick_a(pick_a), .pick_b(pick_b),
        .sel_count(sel_count), .pick_valid(pick_valid),
        .pair_ready(pair_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: where the cursor is and which picks are held.
    int m_cursor = 0;
    int m_a      = 0;
    int m_b      = 0;
    int m_cnt    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_output();
        check("cursor", int'(cursor), m_cursor);
        check("sel_count", int'(sel_count), m_cnt);
        check("pair_ready", int'(pair_ready), (m_cnt == 2) ? 1 : 0);
        check("pick_a", int'(pick_a), m_a);
        check("pick_b", int'(pick_b), m_b);
    endtask

    function automatic int model_move(input int cur, input int dir);
        int res;
        res = (cur + dir + 16) % 16;
`ifdef SKIP_MATCHED_EN
        res = cur;
        for (int k = 15; k >= 1; k--) begin
            if (!matched[(cur + dir * k + 32) % 16]) res = (cur + dir * k + 32) % 16;
        end
`endif
        return res;
    endfunction

    task automatic model_reset();
        m_cursor = 0;
        m_a      = 0;
        m_b      = 0;
        m_cnt    = 0;
    endtask

    // Press the given buttons together, then release; the model is updated
    // up front so the expected pulse is queued before the DUT can emit it.
    task automatic apply_stimulus(input bit l, input bit r, input bit s);
        exp_t e;
        if (enable) begin
            if (s && !matched[m_cursor]) begin
                if (m_cnt == 0) begin
                    m_a   = m_cursor;
                    m_cnt = 1;
                    e.a = m_a; e.b = m_b; e.cnt = m_cnt;
                    exp_q.push_back(e);
                end else if (m_cnt == 1 && m_cursor != m_a) begin
                    m_b   = m_cursor;
                    m_cnt = 2;
                    e.a = m_a; e.b = m_b; e.cnt = m_cnt;
                    exp_q.push_back(e);
                end
            end
            if (l && !r) m_cursor = model_move(m_cursor, -1);
            if (r && !l) m_cursor = model_move(m_cursor, 1);
        end
        @(negedge clk);
        izq = ~l;
        der = ~r;
        sel = ~s;
        repeat (12) @(negedge clk);
        izq = 1'b1;
        der = 1'b1;
        sel = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst && pick_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pick_valid: got pulse, expected none (cursor=%0d)",
                         cursor);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_pick_a", int'(pick_a), e.a);
                check("pulse_pick_b", int'(pick_b), e.b);
                check("pulse_sel_count", int'(sel_count), e.cnt);
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        izq     = 1'b1;
        der     = 1'b1;
        sel     = 1'b1;
        enable  = 1'b1;
        clear   = 1'b0;
        matched = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_pick_valid", int'(pick_valid), 0);
        check_output();
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_output();

        // Three right presses, then wrap left through 0.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            check_output();
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            check_output();
        end
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output();

        // Pick 3, move, pick 4, then a third select is ignored.
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output();
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output();
        do_clear();
        check_output();

        // Same card twice, then a matched card.
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output();
        do_clear();
        matched = 16'h0020;
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output();
        matched = 16'h0000;

        // Two-cycle glitch on select.
        @(negedge clk);
        sel = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b1;
        repeat (16) @(negedge clk);
        check_output();

        // Opposite moves together.
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output();

        // Clear held across the whole select event.
        @(negedge clk);
        sel   = 1'b0;
        clear = 1'b1;
        repeat (12) @(negedge clk);
        sel   = 1'b1;
        clear = 1'b0;
        m_cnt = 0;
        repeat (16) @(negedge clk);
        check_output();

`ifdef SKIP_MATCHED_EN
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        matched = 16'h000E;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check("skip_cursor", int'(cursor), 4);
        check_output();
        matched = 16'h0000;
`endif

        // Reset in the middle of a one-pick state.
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output();
        @(negedge clk);
        rst = 1'b0;
        #2;
        model_reset();
        check("midreset_pick_valid", int'(pick_valid), 0);
        check_output();

        // Select held through reset release gives no event.
        sel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        sel = 1'b1;
        repeat (24) @(negedge clk);
        check_output();

        // Randomized operations.
        for (int n = 0; n < 70; n++) begin
            int op;
            op = int'($urandom_range(0, 10));
            case (op)
                0, 1: apply_stimulus(1'b1, 1'b0, 1'b0);
                2, 3: apply_stimulus(1'b0, 1'b1, 1'b0);
                4, 5: apply_stimulus(1'b0, 1'b0, 1'b1);
                6: begin
                    if ($urandom_range(0, 1) == 1) apply_stimulus(1'b0, 1'b1, 1'b1);
                    else                           apply_stimulus(1'b1, 1'b0, 1'b1);
                end
                7: apply_stimulus(1'b1, 1'b1, 1'b0);
                8: do_clear();
                9: begin
                    @(negedge clk);
                    if ($urandom_range(0, 2) == 0) matched = 16'h0000;
                    else matched = 16'($urandom & $urandom);
                end
                default: begin
                    enable = 1'b0;
                    apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1)));
                    enable = 1'b1;
                end
            endcase
            check_output();
        end

        repeat (20) @(negedge clk);
        check("pending_pulses", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/card_selector.md
CARD_SELECTOR -- requirements
Module: card_selector

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz).
REQ-002 SHALL have ports, in order:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous reset, active-low.
- izq  in  1  raw left button, active-low.
- der  in  1  raw right button, active-low.
- sel  in  1  raw select button, active-low.
- enable  in  1  high while the game FSM accepts card picks.
- matched  in  16  bit i high means card i is already paired.
- clear  in  1  one-cycle pulse from the FSM: pair consumed, discard picks.
- cursor  out  4  highlighted card index.
- pick_a  out  4  first picked card.
- pick_b  out  4  second picked card.
- sel_count  out  2  number of picks held (0, 1 or 2); feeds cartas_seleccionadas.
- pick_valid  out  1  one-cycle pulse per accepted pick; feeds se_eligio_carta.
- pair_ready  out  1  level, high while two picks are held.

Function
REQ-003 SHALL pass each button through a 2-flop synchronizer, then a stability counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-004 SHALL generate one internal 1-cycle event per debounced press (high-to-low transition of the raw input); holding a button SHALL produce no repeat events.
REQ-005 SHALL implement FSM states S_NONE, S_ONE, S_PAIR; sel_count = 0, 1, 2 respectively; pair_ready = (state == S_PAIR).
REQ-006 On a left event, cursor SHALL decrement modulo 16 (0 wraps to 15); on a right event, cursor SHALL increment modulo 16 (15 wraps to 0); the update is visible on the cycle after the event.
REQ-007 Left and right events in the same cycle SHALL leave cursor unchanged.
REQ-008 A select event in S_NONE SHALL load pick_a = cursor, pulse pick_valid, and move to S_ONE.
REQ-009 A select event in S_ONE SHALL load pick_b = cursor, pulse pick_valid, and move to S_PAIR, unless cursor == pick_a.
REQ-010 A select event SHALL be ignored (no pulse, no state change) when matched[cursor] = 1, when cursor == pick_a in S_ONE, or in S_PAIR.
REQ-011 When select and move events coincide, the pick SHALL use the pre-move cursor; the move still applies.
REQ-012 When enable = 0, all events SHALL be discarded; cursor, picks and state SHALL hold. Debouncers keep running.
REQ-013 clear SHALL return the FSM to S_NONE from any state on the next edge and has priority over a same-cycle select; pick_a, pick_b and cursor SHALL hold their values.
REQ-014 pick_valid SHALL be registered, asserted for exactly one cycle, the cycle after the accepted select event.

Reset
REQ-015 While rst = 0: state = S_NONE, cursor = 0, pick_a = 0, pick_b = 0, pick_valid = 0, pair_ready = 0, sel_count = 0.
REQ-016 While rst = 0, the debounced levels SHALL be "released", synchronizers SHALL be 1 and counters 0, so a button held through reset release produces no event.
REQ-017 Reset asserted mid-operation SHALL abort any pick in progress with no pick_valid pulse.

Configuration
REQ-018 With SKIP_MATCHED_EN defined, a move SHALL continue in the same direction past cards with matched = 1, landing on the nearest unmatched card. If all 16 are matched, cursor SHALL hold. The search is completed in the same cycle.
REQ-019 Without SKIP_MATCHED_EN, moves SHALL step by exactly one regardless of matched.

Structure
REQ-020 memory_pkg SHALL hold NUM_CARDS = 16, card_idx_t (4-bit), and the sel_state_t enum.
REQ-021 Debouncing SHALL be a sub-module button_debounce (sync + counter + press event), instantiated three times.

Verification (DEBOUNCE_CYCLES = 4)
REQ-022 Press der three times from reset -> cursor 0->1->2->3; one press of izq at cursor 0 -> cursor 15.
REQ-023 Sel at cursor 3, der, then sel -> pick_valid pulses twice; pick_a = 3, pick_b = 4, sel_count = 2, pair_ready = 1. A further sel -> no pulse.
REQ-024 Sel at 5, then sel at 5 again -> one pulse only, sel_count = 1. With matched[5] = 1, sel at 5 -> no pulse.
REQ-025 Glitch of 2 cycles on sel -> no event. Izq and der pressed together -> cursor unchanged. Clear and sel in the same cycle -> sel_count = 0, no pulse.
REQ-026 SKIP_MATCHED_EN, matched = 16'h000E, cursor 0, der -> cursor 4. Rst pulled low in S_ONE -> all outputs at reset values.
